mips_cycle_controller: RTL and testbench

- Multicycle sequencer for the MIPS core. It generates the fetch/exec1/exec2 phase strobes consumed by the PC, register file and ALU.
- Drives the Avalon-style memory read/write strobes, honouring waitrequest.
- Detects halt (PC reached 0) and bus timeouts, and drives the CPU active flag and performance counters.

---
 rtl/mips_cycle_controller.sv | 164 ++++++++++++++++
 tb/tb_mips_cycle_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mips_cycle_controller.sv
// Multicycle sequencer for the MIPS core: FETCH/EXEC1/MEM/EXEC2 phase strobes,
// Avalon-style read/write requests with waitrequest, halt and bus-timeout detection.
module mips_cycle_controller #(
    parameter int unsigned MAX_WAIT = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             waitrequest,
    input  logic             pc_halt,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             alu_busy,
    output logic             fetch,
    output logic             exec1,
    output logic             exec2,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             active,
    output logic             bus_error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    // The wait counter never has to hold MAX_WAIT itself: the stall that would
    // take it there raises the timeout instead.
    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC1  = 3'd1,
        S_MEM    = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              ir_loaded_q, ir_loaded_d;
    logic              ld_q, ld_d;
    logic              st_q, st_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bus_error_q, bus_error_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
    logic              wait_hit;

    assign wait_hit = (MAX_WAIT != 32'd0) && (wait_cnt_q == WAIT_W'(MAX_WAIT - 32'd1));

    // Next-state, flag and strobe decode.
    always_comb begin
        state_d     = state_q;
        ir_loaded_d = ir_loaded_q;
        ld_d        = ld_q;
        st_d        = st_q;
        wait_cnt_d  = '0;
        bus_error_d = bus_error_q;
        fetch       = 1'b0;
        exec1       = 1'b0;
        exec2       = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        active      = (state_q != S_HALTED);

        case (state_q)
            S_FETCH: begin
                fetch       = 1'b1;
                ir_loaded_d = 1'b0;
                if (pc_halt) begin
                    state_d = S_HALTED;
                end else begin
                    mem_read = 1'b1;
                    if (!waitrequest) begin
                        state_d = S_EXEC1;
                    end else if (wait_hit) begin
                        bus_error_d = 1'b1;
                        state_d     = S_HALTED;
                    end else begin
                        wait_cnt_d = (MAX_WAIT != 32'd0) ? wait_cnt_q + WAIT_W'(1) : '0;
                    end
                end
            end
            S_EXEC1: begin
                exec1       = 1'b1;
                ir_write    = !ir_loaded_q;
                ir_loaded_d = 1'b1;
                if (!alu_busy) begin
                    // Load wins when both are decoded, so the store flag is masked here.
                    ld_d    = is_load;
                    st_d    = is_store & ~is_load;
                    state_d = (is_load | is_store) ? S_MEM : S_EXEC2;
                end else begin
                    state_d = S_EXEC1;
                end
            end
            S_MEM: begin
                mem_read  = ld_q;
                mem_write = st_q;
                if (!waitrequest) begin
                    state_d = S_EXEC2;
                end else if (wait_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = S_HALTED;
                end else begin
                    wait_cnt_d = (MAX_WAIT != 32'd0) ? wait_cnt_q + WAIT_W'(1) : '0;
                end
            end
            S_EXEC2: begin
                exec2       = 1'b1;
                ir_loaded_d = 1'b0;
                state_d     = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        bus_error = bus_error_q;
    end

    // Performance counters; both freeze once halted.
    always_comb begin
        cycle_count = cycle_cnt_q;
        instr_count = instr_cnt_q;
        if (state_q != S_HALTED) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
        if (state_q == S_EXEC2) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end else begin
            instr_cnt_d = instr_cnt_q;
        end
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            ir_loaded_q <= 1'b0;
            ld_q        <= 1'b0;
            st_q        <= 1'b0;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_loaded_q <= ir_loaded_d;
            ld_q        <= ld_d;
            st_q        <= st_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

endmodule

// File: tb/tb_mips_cycle_controller.sv
// Self-checking bench for mips_cycle_controller: each instruction is described by
// its stall/busy/kind parameters and expanded into the expected per-cycle strobes.
module tb_mips_cycle_controller;

    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned CNT_W    = 5;

    // Strobe vector order: fetch exec1 exec2 ir_write mem_read mem_write active bus_error
    localparam logic [7:0] V_FETCH = 8'b1000_1010;
    localparam logic [7:0] V_HALTF = 8'b1000_0010;
    localparam logic [7:0] V_E1FST = 8'b0101_0010;
    localparam logic [7:0] V_E1    = 8'b0100_0010;
    localparam logic [7:0] V_MRD   = 8'b0000_1010;
    localparam logic [7:0] V_MWR   = 8'b0000_0110;
    localparam logic [7:0] V_E2    = 8'b0010_0010;

    logic             clk, reset, waitrequest, pc_halt, is_load, is_store, alu_busy;
    logic             fetch, exec1, exec2, ir_write, mem_read, mem_write, active, bus_error;
    logic [CNT_W-1:0] cycle_count, instr_count;

    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] exp_cyc;
    logic [CNT_W-1:0] exp_instr;
    logic             exp_err;
    logic             halted;

    mips_cycle_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .pc_halt(pc_halt),
        .is_load(is_load), .is_store(is_store), .alu_busy(alu_busy),
        .fetch(fetch), .exec1(exec1), .exec2(exec2), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .active(active),
        .bus_error(bus_error), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance, update the model.
    task automatic cyc(input string tag, input logic wr, input logic ph, input logic ld,
                       input logic st, input logic busy, input logic [7:0] exp);
        logic [7:0] obs;
        waitrequest = wr;
        pc_halt     = ph;
        is_load     = ld;
        is_store    = st;
        alu_busy    = busy;
        #1;
        obs = {fetch, exec1, exec2, ir_write, mem_read, mem_write, active, bus_error};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s strobes observed=%b expected=%b", tag, obs, exp);
        end
        checks++;
        assert (cycle_count === exp_cyc) else begin
            errors++;
            $error("FAIL %s cycle_count observed=%0d expected=%0d", tag, cycle_count, exp_cyc);
        end
        checks++;
        assert (instr_count === exp_instr) else begin
            errors++;
            $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, exp_instr);
        end
        @(posedge clk);
        #1;
        if (exp[1]) exp_cyc = exp_cyc + 1'b1;
        if (exp[5]) exp_instr = exp_instr + 1'b1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        waitrequest = rb();
        pc_halt     = rb();
        is_load     = rb();
        is_store    = rb();
        alu_busy    = rb();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_cyc   = '0;
        exp_instr = '0;
        exp_err   = 1'b0;
        halted    = 1'b0;
    endtask

    task automatic halted_cycles(input int n);
        for (int i = 0; i < n; i++)
            cyc("halted", rb(), rb(), rb(), rb(), rb(), {7'b0, exp_err});
    endtask

    // fs fetch stalls, ab busy cycles, kind ld/st, ms memory stalls; halt_now halts at fetch.
    task automatic run_instr(input int fs, input int ab, input logic ld, input logic st,
                             input int ms, input logic halt_now);
        if (halt_now) begin
            cyc("halt_fetch", rb(), 1'b1, rb(), rb(), rb(), V_HALTF);
            halted = 1'b1;
            return;
        end
        for (int i = 0; i <= fs; i++) begin
            cyc("fetch", (i < fs), 1'b0, rb(), rb(), rb(), V_FETCH);
            if (i < fs && i == MAX_WAIT - 1) begin
                exp_err = 1'b1;
                halted  = 1'b1;
                return;
            end
        end
        for (int j = 0; j <= ab; j++)
            cyc("exec1", rb(), rb(), (j == ab) ? ld : rb(), (j == ab) ? st : rb(),
                (j < ab), (j == 0) ? V_E1FST : V_E1);
        if (ld || st) begin
            for (int k = 0; k <= ms; k++) begin
                cyc("mem", (k < ms), rb(), rb(), rb(), rb(), ld ? V_MRD : V_MWR);
                if (k < ms && k == MAX_WAIT - 1) begin
                    exp_err = 1'b1;
                    halted  = 1'b1;
                    return;
                end
            end
        end
        cyc("exec2", rb(), rb(), rb(), rb(), rb(), V_E2);
    endtask

    initial begin
        int fs, ms;
        int r;
        reset = 1'b1; waitrequest = 1'b0; pc_halt = 1'b0;
        is_load = 1'b0; is_store = 1'b0; alu_busy = 1'b0;
        do_reset();

        run_instr(0, 0, 1'b0, 1'b0, 0, 1'b0);   // plain ALU op
        run_instr(4, 0, 1'b0, 1'b0, 0, 1'b0);   // fetch stall
        run_instr(0, 0, 1'b1, 1'b0, 2, 1'b0);   // load with stalls
        run_instr(0, 0, 1'b0, 1'b1, 2, 1'b0);   // store with stalls
        run_instr(0, 0, 1'b1, 1'b1, 1, 1'b0);   // load wins over store
        run_instr(0, 10, 1'b0, 1'b0, 0, 1'b0);  // long ALU busy
        run_instr(7, 0, 1'b1, 1'b0, 7, 1'b0);   // longest tolerated stalls

        run_instr(0, 0, 1'b0, 1'b0, 0, 1'b1);   // halt at fetch
        halted_cycles(20);
        do_reset();
        run_instr(0, 0, 1'b0, 1'b0, 0, 1'b0);

        run_instr(0, 0, 1'b1, 1'b0, 20, 1'b0);  // MEM timeout
        halted_cycles(5);
        do_reset();
        run_instr(12, 0, 1'b0, 1'b0, 0, 1'b0);  // FETCH timeout
        halted_cycles(3);
        do_reset();

        // Mid-wait reset, then a full tolerated stall proves the wait counter restarted.
        cyc("fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_FETCH);
        cyc("exec1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_E1FST);
        for (int k = 0; k < 5; k++)
            cyc("mem", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_MWR);
        do_reset();
        run_instr(0, 0, 1'b0, 1'b1, 7, 1'b0);

        for (int n = 0; n < 200; n++) begin
            if (halted) begin
                halted_cycles(int'($urandom_range(1, 4)));
                do_reset();
            end
            r  = int'($urandom_range(0, 15));
            fs = (r == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
            ms = (r == 2) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
            run_instr(fs, int'($urandom_range(0, 3)), rb(), rb(), ms, (r == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
